// File: rtl/bus_transfer_sequencer_if.sv
// Command and register-bank control bundle for bus_transfer_sequencer.
//
// Signals:
//   cmd_valid / cmd_ready   command handshake (ready high only while idle)
//   cmd_op                  0 = MOV, 1 = XCHG
//   cmd_src / cmd_dst       register indices
//   reg_oe / reg_we         one-hot-or-zero enables to the register bank
//   temp_oe                 high while the temp latch drives the shared bus
//   bus_in                  current shared bus value, sampled by the temp latch
//   done                    one-cycle completion pulse
//
// Modports: master = command issuer / register bank side,
//           slave  = the sequencer itself.
interface bus_transfer_sequencer_if #(
    parameter int WIDTH     = 8,
    parameter int SEL_WIDTH = 3
);
    localparam int NUM_REGS = 2 ** SEL_WIDTH;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_op;
    logic [SEL_WIDTH-1:0] cmd_src;
    logic [SEL_WIDTH-1:0] cmd_dst;
    logic [NUM_REGS-1:0]  reg_oe;
    logic [NUM_REGS-1:0]  reg_we;
    logic                 temp_oe;
    logic [WIDTH-1:0]     bus_in;
    logic                 done;

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, bus_in,
        input  cmd_ready, reg_oe, reg_we, temp_oe, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, bus_in,
        output cmd_ready, reg_oe, reg_we, temp_oe, done
    );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// Sequences MOV and XCHG transfers on the CPU's shared internal data bus by
// driving the output/write enables of the tri-state register bank, so that
// exactly one source drives the bus in any cycle.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset; drops every enable at once
//   bif      slave side of bus_transfer_sequencer_if (handshake, enables,
//            bus_in sample, temp drive flag, done)
//   bus_out  temp latch drive onto the shared bus, Z when not driving
//
// Every transfer is a drive-only settle cycle (Dn) followed by a drive+write
// cycle (Wn). All enables are registered straight out of the FSM so they are
// free of decode glitches.
module bus_transfer_sequencer #(
    parameter int WIDTH     = 8,
    parameter int SEL_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bus_transfer_sequencer_if.slave bif,
    output tri [WIDTH-1:0]          bus_out
);
    localparam int NUM_REGS = 2 ** SEL_WIDTH;
    localparam logic OP_MOV = 1'b0;

    typedef enum logic [2:0] {IDLE, D1, W1, D2, W2, D3, W3} state_t;

    state_t               state;
    logic                 op_q;
    logic [SEL_WIDTH-1:0] src_q;
    logic [SEL_WIDTH-1:0] dst_q;
    logic [WIDTH-1:0]     temp_q;
    logic [NUM_REGS-1:0]  oe_q;
    logic [NUM_REGS-1:0]  we_q;
    logic                 temp_oe_q;
    logic                 done_q;
    logic                 ready_q;

    function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [SEL_WIDTH-1:0] sel);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

    // Outputs are loaded with the value they must hold in the state being
    // entered, so each register already matches its state during that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= OP_MOV;
            src_q     <= '0;
            dst_q     <= '0;
            temp_q    <= '0;
            oe_q      <= '0;
            we_q      <= '0;
            temp_oe_q <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bif.cmd_valid && ready_q) begin
                        op_q    <= bif.cmd_op;
                        src_q   <= bif.cmd_src;
                        dst_q   <= bif.cmd_dst;
                        oe_q    <= sel_onehot(bif.cmd_src);
                        ready_q <= 1'b0;
                        state   <= D1;
                    end
                end
                D1: begin
                    // XCHG's first pair writes the temp latch, not a register.
                    if (op_q == OP_MOV) begin
                        we_q <= sel_onehot(dst_q);
                    end
                    state <= W1;
                end
                W1: begin
                    we_q <= '0;
                    if (op_q == OP_MOV) begin
                        oe_q    <= '0;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        temp_q <= bif.bus_in;
                        oe_q   <= sel_onehot(dst_q);
                        state  <= D2;
                    end
                end
                D2: begin
                    we_q  <= sel_onehot(src_q);
                    state <= W2;
                end
                W2: begin
                    // Register driver hands over to the temp latch with no overlap.
                    oe_q      <= '0;
                    we_q      <= '0;
                    temp_oe_q <= 1'b1;
                    state     <= D3;
                end
                D3: begin
                    we_q  <= sel_onehot(dst_q);
                    state <= W3;
                end
                W3: begin
                    we_q      <= '0;
                    temp_oe_q <= 1'b0;
                    done_q    <= 1'b1;
                    ready_q   <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    oe_q      <= '0;
                    we_q      <= '0;
                    temp_oe_q <= 1'b0;
                    ready_q   <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bif.cmd_ready = ready_q;
    assign bif.reg_oe    = oe_q;
    assign bif.reg_we    = we_q;
    assign bif.temp_oe   = temp_oe_q;
    assign bif.done      = done_q;
    assign bus_out       = temp_oe_q ? temp_q : {WIDTH{1'bz}};
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Testbench for bus_transfer_sequencer with a behavioural register bank.
module tb_bus_transfer_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    wire  [7:0] bus_out;

    bus_transfer_sequencer_if #(.WIDTH(8), .SEL_WIDTH(3)) bif ();

    bus_transfer_sequencer #(.WIDTH(8), .SEL_WIDTH(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bif    (bif),
        .bus_out(bus_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int acc_cnt  = 0;

    // register bank driven by the DUT enables
    logic [7:0] regs  [8];
    logic [7:0] mregs [8];
    logic [7:0] bus_val;
    logic       pre_we;
    logic [2:0] pre_idx;
    logic [7:0] pre_val;

    function automatic logic [2:0] oh_idx(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    always_comb begin
        bus_val = 8'h00;
        if (bif.temp_oe) bus_val = bus_out;
        else for (int i = 0; i < 8; i++) if (bif.reg_oe[i]) bus_val = regs[i];
    end
    assign bif.bus_in = bus_val;

    always @(posedge clk) begin
        if (pre_we) regs[pre_idx] <= pre_val;
        else if (bif.reg_we != 8'h00) regs[oh_idx(bif.reg_we)] <= bus_val;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return 32'({bif.reg_oe, bif.reg_we, bif.temp_oe, bif.done, bif.cmd_ready});
    endfunction

    // continuous protocol checks and counters
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            int drivers;
            logic ok;
            drivers = $countones(bif.reg_oe) + int'(bif.temp_oe);
            ok = (drivers <= 1) && $onehot0(bif.reg_we) && (bif.reg_we == 8'h00 || drivers == 1);
            chk("protocol_single_driver", 32'(ok), 32'd1);
            if (bif.done) done_cnt++;
        end
    end

    initial forever begin
        @(posedge clk);
        if (rst_n && bif.cmd_valid && bif.cmd_ready) acc_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Starts and ends on a negedge with the DUT idle.
    task automatic preset(input int idx, input logic [7:0] val);
        pre_we  = 1'b1;
        pre_idx = 3'(idx);
        pre_val = val;
        mregs[idx] = val;
        @(posedge clk);
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issues one command at the current negedge and checks every cycle up to
    // and including the done cycle against a transfer-list model.
    task automatic run_cmd(input bit op, input int src, input int dst, output time t_done);
        int drv [3];
        int wr  [3];
        int n;
        logic [7:0] tmpv;
        logic [7:0] e_oe, e_we;
        logic e_t;
        logic [7:0] sv;
        bit bank_ok;
        // each transfer: driver (8 = temp latch), write target (-1 = temp latch)
        if (!op) begin
            n = 1; drv[0] = src; wr[0] = dst;
        end else begin
            n = 3;
            drv[0] = src; wr[0] = -1;
            drv[1] = dst; wr[1] = src;
            drv[2] = 8;   wr[2] = dst;
        end
        tmpv = mregs[src];
        chk("ready_at_issue", 32'(bif.cmd_ready), 32'd1);
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = op;
        bif.cmd_src   = 3'(src);
        bif.cmd_dst   = 3'(dst);
        @(posedge clk);
        for (int t = 0; t < n; t++) begin
            for (int ph = 0; ph < 2; ph++) begin
                @(negedge clk);
                bif.cmd_valid = 1'($urandom);
                bif.cmd_op    = 1'($urandom);
                bif.cmd_src   = 3'($urandom);
                bif.cmd_dst   = 3'($urandom);
                e_oe = (drv[t] < 8) ? 8'(1 << drv[t]) : 8'h00;
                e_t  = (drv[t] == 8);
                e_we = (ph == 1 && wr[t] >= 0) ? 8'(1 << wr[t]) : 8'h00;
                chk($sformatf("busy_t%0d_ph%0d_enables", t, ph), obs(),
                    32'({e_oe, e_we, e_t, 1'b0, 1'b0}));
                if (e_t) chk("temp_bus_out", 32'(bus_out), 32'(tmpv));
            end
        end
        @(negedge clk);
        bif.cmd_valid = 1'b0;
        chk("done_cycle", obs(), 32'h0000_0003);
        t_done = $time;
        if (!op) mregs[dst] = mregs[src];
        else begin
            sv = mregs[src];
            mregs[src] = mregs[dst];
            mregs[dst] = sv;
        end
        bank_ok = 1'b1;
        for (int i = 0; i < 8; i++) if (regs[i] !== mregs[i]) bank_ok = 1'b0;
        chk("bank_vs_model", 32'(bank_ok), 32'd1);
    endtask

    typedef struct {
        bit         op;
        int         src;
        int         dst;
        logic [7:0] vsrc;
        logic [7:0] vdst;
        logic [7:0] esrc;
        logic [7:0] edst;
    } vec_t;

    vec_t vecs [6];

    initial begin
        time t1, t2;
        int done_before;
        vecs[0] = '{1'b0, 2, 5, 8'hA5, 8'h00, 8'hA5, 8'hA5};
        vecs[1] = '{1'b1, 1, 3, 8'h11, 8'h22, 8'h22, 8'h11};
        vecs[2] = '{1'b0, 4, 4, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
        vecs[3] = '{1'b1, 6, 6, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        vecs[4] = '{1'b1, 0, 7, 8'h01, 8'hFE, 8'hFE, 8'h01};
        vecs[5] = '{1'b0, 7, 0, 8'hC3, 8'h99, 8'hC3, 8'hC3};

        rst_n = 1'b0;
        pre_we = 1'b0; pre_idx = 3'd0; pre_val = 8'h00;
        bif.cmd_valid = 1'b0; bif.cmd_op = 1'b0; bif.cmd_src = 3'd0; bif.cmd_dst = 3'd0;

        // reset state with the clock running
        repeat (3) @(negedge clk);
        chk("reset_state", obs(), 32'h0000_0001);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_after_reset", obs(), 32'h0000_0001);
        end
        for (int i = 0; i < 8; i++) preset(i, 8'(8'h10 * i + i));

        // table-driven commands
        for (int i = 0; i < 6; i++) begin
            preset(vecs[i].src, vecs[i].vsrc);
            preset(vecs[i].dst, vecs[i].vdst);
            run_cmd(vecs[i].op, vecs[i].src, vecs[i].dst, t1);
            chk($sformatf("vec%0d_src", i), 32'(regs[vecs[i].src]), 32'(vecs[i].esrc));
            chk($sformatf("vec%0d_dst", i), 32'(regs[vecs[i].dst]), 32'(vecs[i].edst));
            @(negedge clk);
        end

        // back-to-back MOVs, second accepted in the first's done cycle
        preset(0, 8'h5E);
        preset(1, 8'h00);
        preset(2, 8'h77);
        run_cmd(1'b0, 0, 1, t1);
        run_cmd(1'b0, 1, 2, t2);
        chk("b2b_done_spacing", 32'(t2 - t1), 32'd30);
        chk("b2b_reg2", 32'(regs[2]), 32'h5E);
        @(negedge clk);

        // reset during D2 of XCHG 1<->3
        preset(1, 8'h11);
        preset(3, 8'h22);
        done_before = done_cnt;
        chk("rst_mid_ready", 32'(bif.cmd_ready), 32'd1);
        bif.cmd_valid = 1'b1; bif.cmd_op = 1'b1; bif.cmd_src = 3'd1; bif.cmd_dst = 3'd3;
        @(posedge clk);
        @(negedge clk);
        bif.cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rst_mid_in_d2", obs(), 32'({8'h08, 8'h00, 3'b000}));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_async_clear", obs(), 32'h0000_0001);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_after_release", obs(), 32'h0000_0001);
        chk("rst_mid_reg1", 32'(regs[1]), 32'h11);
        chk("rst_mid_reg3", 32'(regs[3]), 32'h22);
        chk("rst_mid_no_done", 32'(done_cnt), 32'(done_before));

        // randomized commands against the model
        for (int i = 0; i < 8; i++) preset(i, 8'($urandom));
        for (int k = 0; k < 40; k++) begin
            bit op;
            int s, d, gap;
            op  = 1'($urandom);
            s   = int'($urandom_range(0, 7));
            d   = ($urandom_range(0, 3) == 0) ? s : int'($urandom_range(0, 7));
            gap = int'($urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0) preset(int'($urandom_range(0, 7)), 8'($urandom));
            run_cmd(op, s, d, t1);
            repeat (gap) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("done_vs_accepted", 32'(done_cnt), 32'(acc_cnt - 1));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_transfer_sequencer.md
# bus_transfer_sequencer

Control stage that sits directly upstream of the CPU's bank of tri-state bus registers. It drives their per-register output and write enables so that exactly one source drives the shared internal data bus at a time. It executes two commands:

- **MOV**: copy a source register into a destination register.
- **XCHG**: swap two registers, using an internal temporary latch.

Each command is accepted through a valid/ready handshake, and completion is signalled with a one-cycle `done` pulse.

## Interface

Parameters:
- `WIDTH`, 8, data bus width.
- `SEL_WIDTH`, 3, register-select width; `NUM_REGS` = 2**`SEL_WIDTH`.

Ports:
- `clk`  input  1  — single clock; all state changes on the rising edge.
- `rst_n`  input  1  — asynchronous, active-low reset.
- `cmd_valid`  input  1  — command request.
- `cmd_ready`  output  1  — high when a command can be accepted.
- `cmd_op`  input  1  — 0 = MOV, 1 = XCHG.
- `cmd_src`  input  `SEL_WIDTH`  — source register index.
- `cmd_dst`  input  `SEL_WIDTH`  — destination register index.
- `reg_oe`  output  `NUM_REGS`  — one-hot-or-zero output enables to the register bank.
- `reg_we`  output  `NUM_REGS`  — one-hot-or-zero write enables to the register bank.
- `bus_in`  input  `WIDTH`  — shared bus value, sampled into the temp latch.
- `bus_out`  output (tri)  `WIDTH`  — temp latch drive onto the bus; Z when not driving.
- `done`  output  1  — one-cycle completion pulse.

## Operation

- **States:** IDLE, D1, W1, D2, W2, D3, W3.
- **IDLE:** `cmd_ready`=1. When `cmd_valid`&&`cmd_ready` at a rising edge:
  - latch `cmd_op`, `cmd_src` and `cmd_dst`;
  - go to D1.
- **Command fields:** ignored in every state except IDLE. `cmd_valid` held while busy has no effect.
- **Drive/write pairs:** every transfer is a Dn (drive only, bus settle) cycle followed by a Wn (same driver plus one write enable) cycle. The destination captures at the rising edge that ends Wn.

MOV sequence:
- D1: `reg_oe[src]`.
- W1: `reg_oe[src]` + `reg_we[dst]`.
- Then → IDLE.

XCHG sequence:
- D1: `reg_oe[src]`.
- W1: `reg_oe[src]`; temp latch captures `bus_in` at the end of W1.
- D2: `reg_oe[dst]`.
- W2: `reg_oe[dst]` + `reg_we[src]`.
- D3: temp drives `bus_out`.
- W3: temp drives `bus_out` + `reg_we[dst]`.
- Then → IDLE.

Output and invariant rules:
- **`done`:** registered; high for exactly the one cycle after the final W cycle, i.e. the first IDLE cycle.
- **Enables:** `reg_oe`, `reg_we` and the temp drive enable are Moore outputs decoded from state and the latched command. They must be glitch-free.
- **Single driver:** in every cycle, popcount(`reg_oe`) + temp_drive ≤ 1.
- **Write enables:** `reg_we` is never more than one-hot, and is never asserted without exactly one driver.
- **src == dst:** executes the full normal sequence with no special case. The register value is unchanged. MOV takes 2 busy cycles, XCHG takes 6.
- **Reset mid-operation:**
  - all enables drop to 0 and `bus_out` goes to Z immediately (asynchronously);
  - the command is abandoned, no `done` is produced, and state returns to IDLE;
  - writes already completed at earlier edges stand.

## Timing

- **Reset values:**
  - state IDLE, `cmd_ready`=1 (no edge is sampled while `rst_n`=0);
  - `reg_oe`=0, `reg_we`=0, `done`=0;
  - `bus_out`=Z, temp latch = 0.
- **MOV latency:** accepted at edge E0. D1 is in cycle E0→E1, W1 in E1→E2; the destination is updated at E2. `done`=1 and `cmd_ready`=1 in cycle E2→E3.
- **XCHG latency:** accepted at edge E0. The source is updated at E4 and the destination at E6. `done` is high in E6→E7.
- **Back-to-back:** a new command can be accepted at the edge ending the `done` cycle. Sustained throughput is therefore 3 cycles per MOV and 7 cycles per XCHG.
- **`cmd_ready`:** low in all non-IDLE states.

## Test plan

- **Reset:** hold `rst_n`=0 and toggle `clk`. Expect `reg_oe`=0, `reg_we`=0, `done`=0, `bus_out`=Z and `cmd_ready`=1. After release, no enables assert until a command arrives.
- **MOV:** reg2=0xA5, MOV src=2 dst=5.
  - Cycle 1: `reg_oe`=0x04.
  - Cycle 2: `reg_oe`=0x04, `reg_we`=0x20.
  - Cycle 3: `done`=1.
  - Result: reg5=0xA5, reg2=0xA5.
- **XCHG:** reg1=0x11, reg3=0x22, XCHG src=1 dst=3.
  - 6 busy cycles with the exact oe/we sequence listed under Operation.
  - `bus_out`=0x11 during D3 and W3.
  - Result: reg1=0x22, reg3=0x11; `done` pulses once.
- **Back-to-back:** `cmd_valid` held high with MOV 0→1 then MOV 1→2. The second command is accepted in the `done` cycle of the first. reg2 ends equal to the original reg0, with a 3-cycle spacing between `done` pulses.
- **Reset mid-XCHG:** assert `rst_n`=0 during D2 of an XCHG 1↔3. Expect:
  - all enables to 0 and `bus_out`=Z without a clock edge;
  - reg1=0x11 and reg3=0x22 unchanged;
  - no `done` pulse, and `cmd_ready`=1 after release.
- **Protocol checks:** run a continuous assertion over random commands, including src==dst and `cmd_valid` toggling while busy. Check:
  - at most one bus driver per cycle;
  - `reg_we` never asserted without a driver;
  - `done` pulse count equals the accepted command count.
